// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full adder, LSB first.
// Operands arrive and results leave over valid/ready handshakes.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
    input  logic             add_co,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE.

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ? 1'b1 : op_cin;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Zeros shift into A/B, so the adder inputs are already 0 once all bits are used.
                res_d   = {add_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = add_co;
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    cout_d      = add_co;
                    carry_d     = 1'b0;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Adder inputs come straight from flops so the external adder sees no glitches.
    assign add_a     = a_q[0];
    assign add_b     = b_q[0];
    assign add_ci    = carry_q;
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl with a behavioural full adder
// and an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         add_a, add_b, add_ci;
    logic         add_sum, add_co;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_sum(add_sum), .add_co(add_co),
        .dbg_state(dbg_state)
    );

    // External 1-bit full adder
    assign add_sum = add_a ^ add_b ^ add_ci;
    assign add_co  = (add_a & add_b) | (add_ci & (add_a ^ add_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {cout, result}: add is a+b+cin; subtract is (a-b) mod 2^W with cout = no borrow.
    function automatic logic [W:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
        longint ra = a;
        longint rb = b;
        longint r;
        if (sub) begin
            r = (ra >= rb) ? (ra - rb) : (ra - rb + (longint'(1) << W));
            return {(ra >= rb), r[W-1:0]};
        end
        r = ra + rb + cin;
        return r[W:0];
    endfunction

    function automatic longint eff_b(logic [W-1:0] b, logic sub);
        longint rb = b;
        return sub ? ((longint'(1) << W) - 1 - rb) : rb;
    endfunction

    // Carry entering bit position c of the effective addition
    function automatic logic exp_carry(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub, int c);
        longint m  = (longint'(1) << c) - 1;
        longint ra = a;
        longint s  = (ra & m) + (eff_b(b, sub) & m) + (sub ? 1 : cin);
        return s[c];
    endfunction

    task automatic drive_noise();
        in_valid = 1'($urandom_range(0, 1));
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        op_cin   = 1'($urandom_range(0, 1));
        op_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_iso(input string tag);
        check({tag, "_add_abc"}, {add_a, add_b, add_ci}, 3'b000);
    endtask

    // Called just after a negedge in IDLE. Returns just after the negedge following the output handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int hold, input int abort_bit);
        int c;
        logic [W:0] e;
        longint bb;
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        op_a = a; op_b = b; op_cin = cin; op_sub = sub;
        exp_q.push_back(ref_op(a, b, cin, sub));
        bb = eff_b(b, sub);
        @(posedge clk);
        for (c = 0; c < 4 * W; c++) begin
            @(negedge clk);
            if (out_valid) break;
            check("run_in_ready", in_ready, 1'b0);
            if (c < W) begin
                check("bit_a", add_a, a[c]);
                check("bit_b", add_b, bb[c]);
                check("bit_ci", add_ci, exp_carry(a, b, cin, sub, c));
            end
            if (c == abort_bit) begin
                rst = 1'b1;
                #1;
                check("rst_in_ready", in_ready, 1'b0);
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_result", result, '0);
                check("rst_cout", cout, 1'b0);
                check_iso("rst");
                exp_q.delete();
                in_valid = 1'b0;
                @(negedge clk);
                check("rst_hold_out_valid", out_valid, 1'b0);
                rst = 1'b0;
                #1;
                check("rst_release_ready", in_ready, 1'b1);
                return;
            end
            drive_noise();
        end
        check("latency", c, W);
        if (!out_valid || exp_q.size() == 0) begin
            in_valid = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        check("result", result, e[W-1:0]);
        check("cout", cout, e[W]);
        check("done_in_ready", in_ready, 1'b0);
        check_iso("done");
        for (int h = 0; h < hold; h++) begin
            drive_noise();
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_result", result, e[W-1:0]);
            check("hold_cout", cout, e[W]);
            check("hold_in_ready", in_ready, 1'b0);
            check_iso("hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_result", result, e[W-1:0]);
        check_iso("idle");
    endtask

    initial begin : main
        logic [W:0] e;
        int last_idx;
        int accepts;
        int drained;

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, '0);
        check("reset_cout", cout, 1'b0);
        check_iso("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);

        // Idle isolation with noisy operands but no request
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_noise();
            in_valid = 1'b0;
            check_iso("idle_noise");
            check("idle_out_valid", out_valid, 1'b0);
        end
        @(negedge clk);

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, -1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, -1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 0, -1);
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, -1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, -1);
        run_op(8'h37, 8'h21, 1'b0, 1'b0, 5, -1);

        // Reset during bit 4, then a clean op afterwards
        run_op(8'hC3, 8'h5E, 1'b1, 1'b0, 0, 4);
        @(negedge clk);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, -1);

        // Back-to-back: in_valid and out_ready held high; accepts spaced WIDTH+2 apart
        in_valid = 1'b1; out_ready = 1'b1;
        op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0; op_sub = 1'b0;
        e = ref_op(8'h12, 8'h34, 1'b0, 1'b0);
        last_idx = -1;
        accepts = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (i > 0) @(negedge clk);
            if (in_ready) begin
                accepts++;
                if (last_idx >= 0) check("b2b_gap", i - last_idx, W + 2);
                last_idx = i;
            end
            if (out_valid) begin
                check("b2b_result", result, e[W-1:0]);
                check("b2b_cout", cout, e[W]);
            end
        end
        check("b2b_accepts", accepts, 3);
        in_valid = 1'b0;
        drained = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (in_ready) begin
                drained = 1;
                break;
            end
        end
        check("b2b_drain", drained, 1);
        out_ready = 1'b0;

        // Random regression
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                op_a = W'($urandom);
                in_valid = 1'b0;
                @(negedge clk);
                check_iso("gap");
            end
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
